// File: rtl/avalon_st_source_interface_if.sv
// Avalon-ST source bundle: core-side pixel input, downstream-side
// Avalon-ST output and the frame_done status pulse.
interface avalon_st_source_interface_if;
    // core -> block
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    // block -> downstream sink
    logic        ready;
    logic        valid;
    logic [15:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        frame_done;

    // the source block itself
    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        input  ready,
        output valid,
        output data,
        output startofpacket,
        output endofpacket,
        output frame_done
    );

    // core plus downstream sink as seen from outside the block
    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        output ready,
        input  valid,
        input  data,
        input  startofpacket,
        input  endofpacket,
        input  frame_done
    );
endinterface

// File: rtl/avalon_st_source_interface.sv
// Avalon-ST pixel source: tags each accepted RGB565 pixel with sop/eop from
// x/y framing counters and pushes it through a two-entry skid buffer
// (output register + skid register) so in_ready can be registered while
// still sustaining one pixel per cycle under backpressure.
module avalon_st_source_interface #(
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 240
) (
    input  logic                          clk,
    input  logic                          reset,
    avalon_st_source_interface_if.master  io_st
);

    localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    // data and its framing tags always move together
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] data;
    } beat_t;

    state_t        r_state;
    beat_t         r_out;
    beat_t         r_skid;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_in_ready;
    logic          r_frame_done;

    logic          w_accept;
    logic          w_xfer;
    logic          w_valid;
    logic          w_x_last;
    logic          w_y_last;
    beat_t         w_in_beat;

    assign w_valid   = (r_state != S_EMPTY);
    assign w_accept  = io_st.in_valid && r_in_ready;
    assign w_xfer    = w_valid && io_st.ready;
    assign w_x_last  = (r_x == X_LAST);
    assign w_y_last  = (r_y == Y_LAST);
    assign w_in_beat = '{sop:  (r_x == '0) && (r_y == '0),
                         eop:  w_x_last && w_y_last,
                         data: io_st.in_data};

    // Framing position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Skid-buffer FSM; in_ready is registered from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_out      <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_out   <= w_in_beat;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_xfer) begin
                        r_out      <= w_in_beat;
                        r_in_ready <= 1'b1;
                    end else if (w_accept) begin
                        // downstream stalled: park the new pixel behind the held one
                        r_skid     <= w_in_beat;
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_xfer) begin
                        // data is left in place; tags are masked by valid
                        r_state    <= S_EMPTY;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_xfer) begin
                        r_out      <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Pulse once the cycle after the end-of-frame beat leaves the block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && r_out.eop;
        end
    end

    assign io_st.in_ready      = r_in_ready;
    assign io_st.valid         = w_valid;
    assign io_st.data          = r_out.data;
    assign io_st.startofpacket = w_valid && r_out.sop;
    assign io_st.endofpacket   = w_valid && r_out.eop;
    assign io_st.frame_done    = r_frame_done;

endmodule

// File: tb/tb_avalon_st_source_interface.sv
// Scoreboard bench: dut_a uses the default 320x240 frame, dut_b a 4x2 frame
// so wrap-around, backpressure, reset and idle-gap framing stay short.
module tb_avalon_st_source_interface;
  localparam int AW = 320, AH = 240, BW = 4, BH = 2;
  localparam int FS_A = AW * AH, FS_B = BW * BH;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic live_a = 1'b0, live_b = 1'b0;
  int   cyc_cnt = 0;
  int   n_chk = 0, n_err = 0;
  int   rdy_mode_a = 0, rdy_mode_b = 0;   // 0: ready=1, 1: pattern, 2: ready=0
  logic [5:0] pat = 6'b101001;            // bit i = ready in pattern slot i: 1,0,0,1,0,1

  logic [17:0] qa[$], qb[$];
  int acc_a = 0, acc_b = 0, pre_a = 0, pre_b = 0;

  logic        prev_stall[2], prev_eop_x[2];
  logic [17:0] prev_word[2];
  logic [15:0] last_data[2], eop_data[2];
  logic [31:0] sop_mask[2], eop_mask[2];
  int          xfer_cnt[2], fd_cnt[2], sop_cnt[2], eop_cnt[2], irlow_cnt[2], eop_idx[2];

  always #5 clk = ~clk;

  avalon_st_source_interface_if ifa ();
  avalon_st_source_interface_if ifb ();

  avalon_st_source_interface #(.FRAME_W(AW), .FRAME_H(AH)) dut_a (
    .clk(clk), .reset(rst_a), .io_st(ifa.master));
  avalon_st_source_interface #(.FRAME_W(BW), .FRAME_H(BH)) dut_b (
    .clk(clk), .reset(rst_b), .io_st(ifb.master));

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, d, act, exp, cyc_cnt);
    end
  endtask

  // expected {sop, eop, data} for the cnt-th pixel accepted since reset
  function automatic logic [17:0] tag(input int cnt, input int fs, input logic [15:0] v);
    int idx;
    idx = cnt % fs;
    return {idx == 0, idx == fs - 1, v};
  endfunction

  task automatic waitc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // present one pixel, hold it until accepted (bounded), return at edge+1
  task automatic send(input int d, input logic [15:0] v);
    int t;
    t = 0;
    if (d == 0) begin ifa.in_valid = 1'b1; ifa.in_data = v; end
    else        begin ifb.in_valid = 1'b1; ifb.in_data = v; end
    @(negedge clk);
    while (((d == 0) ? ifa.in_ready : ifb.in_ready) !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", d, 32'(t), 32'd0);
    @(posedge clk); #1;
    if (d == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
  endtask

  // ready drivers
  initial begin
    ifa.ready = 1'b1;
    ifb.ready = 1'b1;
    forever begin
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        ifa.ready = (rdy_mode_a == 0) ? 1'b1 : (rdy_mode_a == 1) ? pat[i] : 1'b0;
        ifb.ready = (rdy_mode_b == 0) ? 1'b1 : (rdy_mode_b == 1) ? pat[i] : 1'b0;
      end
    end
  end

  // reset level seen by the DUT at its last edge, and a cycle counter
  initial forever begin
    @(posedge clk);
    live_a = rst_a;
    live_b = rst_b;
    cyc_cnt++;
  end

  // stimulus recorder: push the expected beat for every accept
  initial forever begin
    @(negedge clk);
    if (!rst_a) begin qa.delete(); acc_a = 0; pre_a = 0; end
    else begin
      pre_a = qa.size();
      if (ifa.in_valid && ifa.in_ready) begin qa.push_back(tag(acc_a, FS_A, ifa.in_data)); acc_a++; end
    end
    if (!rst_b) begin qb.delete(); acc_b = 0; pre_b = 0; end
    else begin
      pre_b = qb.size();
      if (ifb.in_valid && ifb.in_ready) begin qb.push_back(tag(acc_b, FS_B, ifb.in_data)); acc_b++; end
    end
  end

  task automatic mon_step(input int d, input logic on, input logic v, input logic r,
                          input logic [15:0] dat, input logic s, input logic e,
                          input logic fd, input logic ir, input int pre);
    logic [17:0] w, exp;
    int qs;
    w = {s, e, dat};
    if (!on) begin
      prev_stall[d] = 1'b0; prev_eop_x[d] = 1'b0; prev_word[d] = '0; last_data[d] = '0;
      xfer_cnt[d] = 0; fd_cnt[d] = 0; sop_cnt[d] = 0; eop_cnt[d] = 0; irlow_cnt[d] = 0;
      eop_idx[d] = -1; sop_mask[d] = '0; eop_mask[d] = '0; eop_data[d] = '0;
      return;
    end
    chk("frame_done", d, 32'(fd), 32'(prev_eop_x[d]));
    chk("in_ready", d, 32'(ir), 32'(pre != 2));
    chk("in_flight_le2", d, 32'(pre <= 2), 32'd1);
    if (prev_stall[d]) begin
      chk("valid_hold", d, 32'(v), 32'd1);
      chk("word_hold", d, 32'(w), 32'(prev_word[d]));
    end
    if (!v) begin
      chk("idle_tags", d, 32'({s, e}), 32'd0);
      chk("idle_data_hold", d, 32'(dat), 32'(last_data[d]));
    end
    if (v && r) begin
      qs = (d == 0) ? qa.size() : qb.size();
      chk("q_nonempty", d, 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        exp = (d == 0) ? qa.pop_front() : qb.pop_front();
        chk("beat", d, 32'(w), 32'(exp));
      end
      if (s) begin sop_cnt[d]++; if (xfer_cnt[d] < 32) sop_mask[d][xfer_cnt[d]] = 1'b1; end
      if (e) begin
        eop_cnt[d]++; eop_idx[d] = xfer_cnt[d]; eop_data[d] = dat;
        if (xfer_cnt[d] < 32) eop_mask[d][xfer_cnt[d]] = 1'b1;
      end
      xfer_cnt[d]++;
    end
    if (fd) fd_cnt[d]++;
    if (!ir) irlow_cnt[d]++;
    prev_stall[d] = v && !r;
    prev_word[d]  = w;
    prev_eop_x[d] = v && r && e;
    last_data[d]  = dat;
  endtask

  // monitor: compare whatever the DUTs present against the scoreboard
  initial forever begin
    @(negedge clk); #1;
    mon_step(0, rst_a && live_a, ifa.valid, ifa.ready, ifa.data, ifa.startofpacket,
             ifa.endofpacket, ifa.frame_done, ifa.in_ready, pre_a);
    mon_step(1, rst_b && live_b, ifb.valid, ifb.ready, ifb.data, ifb.startofpacket,
             ifb.endofpacket, ifb.frame_done, ifb.in_ready, pre_b);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;

    // reset values with random core activity
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ifa.in_valid = 1'($urandom_range(0, 1));
      ifa.in_data  = 16'($urandom);
      @(negedge clk);
      chk("rst_valid", 0, 32'(ifa.valid), 32'd0);
      chk("rst_data", 0, 32'(ifa.data), 32'd0);
      chk("rst_tags", 0, 32'({ifa.startofpacket, ifa.endofpacket}), 32'd0);
      chk("rst_in_ready", 0, 32'(ifa.in_ready), 32'd0);
      chk("rst_frame_done", 0, 32'(ifa.frame_done), 32'd0);
    end
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1; ifa.in_valid = 1'b0;
    waitc(1);
    @(negedge clk);
    chk("release_in_ready", 0, 32'(ifa.in_ready), 32'd1);
    chk("release_in_ready", 1, 32'(ifb.in_ready), 32'd1);

    // single-pixel latency
    @(posedge clk); #1;
    ifa.in_valid = 1'b1; ifa.in_data = 16'hA5A5;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", 0, 32'(ifa.valid), 32'd1);
    chk("lat_data", 0, 32'(ifa.data), 32'h0000A5A5);
    chk("lat_sop", 0, 32'(ifa.startofpacket), 32'd1);
    waitc(1);
    @(negedge clk);
    chk("lat_drain", 0, 32'(ifa.valid), 32'd0);

    // restart framing, then one full default frame at full rate
    @(posedge clk); #1; rst_a = 1'b0;
    @(posedge clk); #1; rst_a = 1'b1;
    waitc(1);
    t0 = cyc_cnt;
    for (int i = 0; i < FS_A; i++) send(0, 16'(i));
    chk("frame_cycles", 0, 32'(cyc_cnt - t0), 32'(FS_A));
    waitc(3);
    chk("frame_fd_cnt", 0, 32'(fd_cnt[0]), 32'd1);
    chk("frame_sop_cnt", 0, 32'(sop_cnt[0]), 32'd1);
    chk("frame_sop_first", 0, sop_mask[0], 32'h1);
    chk("frame_eop_cnt", 0, 32'(eop_cnt[0]), 32'd1);
    chk("frame_eop_idx", 0, 32'(eop_idx[0]), 32'd76799);
    chk("frame_eop_data", 0, 32'(eop_data[0]), 32'h00002BFF);
    chk("frame_xfers", 0, 32'(xfer_cnt[0]), 32'(FS_A));

    // mid-frame reset of the default DUT while FULL
    for (int i = 0; i < 200; i++) send(0, 16'(16'h4000 + i));
    waitc(2);
    rdy_mode_a = 2;
    waitc(2);
    send(0, 16'hBEE1);
    send(0, 16'hBEE2);
    @(negedge clk);
    chk("a_full_in_ready", 0, 32'(ifa.in_ready), 32'd0);
    @(posedge clk); #1; rst_a = 1'b0; rdy_mode_a = 0;
    waitc(1);
    @(negedge clk);
    chk("a_midrst_valid", 0, 32'(ifa.valid), 32'd0);
    chk("a_midrst_data", 0, 32'(ifa.data), 32'd0);
    @(posedge clk); #1; rst_a = 1'b1;
    waitc(1);
    send(0, 16'h1111);
    send(0, 16'h2222);
    waitc(3);
    chk("a_post_rst_sop", 0, sop_mask[0], 32'h1);
    chk("a_post_rst_xfers", 0, 32'(xfer_cnt[0]), 32'd2);

    // 4x2 wrap-around, data = beat index
    for (int i = 0; i < 20; i++) send(1, 16'(i));
    waitc(3);
    chk("wrap_sop_mask", 1, sop_mask[1], 32'h00010101);
    chk("wrap_eop_mask", 1, eop_mask[1], 32'h00008080);
    chk("wrap_fd_cnt", 1, 32'(fd_cnt[1]), 32'd2);

    // backpressure with ready pattern 1,0,0,1,0,1
    rdy_mode_b = 1;
    for (int i = 1; i <= 24; i++) send(1, 16'(i));
    rdy_mode_b = 0;
    waitc(4);
    chk("bp_drained", 1, 32'(qb.size()), 32'd0);
    chk("bp_saw_full", 1, 32'(irlow_cnt[1] != 0), 32'd1);
    chk("bp_xfers", 1, 32'(xfer_cnt[1]), 32'd44);

    // idle gap mid-line: beats 44,45 then 5 idle cycles then 46,47 (47 = eop)
    send(1, 16'h0100);
    send(1, 16'h0101);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("gap_valid", 1, 32'(ifb.valid), 32'd0);
        chk("gap_tags", 1, 32'({ifb.startofpacket, ifb.endofpacket}), 32'd0);
      end
      @(posedge clk); #1;
    end
    send(1, 16'h0102);
    send(1, 16'h0103);
    waitc(3);
    chk("gap_eop_idx", 1, 32'(eop_idx[1]), 32'd47);
    chk("gap_eop_data", 1, 32'(eop_data[1]), 32'h00000103);
    chk("gap_fd_cnt", 1, 32'(fd_cnt[1]), 32'd6);

    // mid-frame reset of the 4x2 DUT while FULL
    rdy_mode_b = 2;
    waitc(2);
    send(1, 16'h0148);
    send(1, 16'h0149);
    @(negedge clk);
    chk("b_full_in_ready", 1, 32'(ifb.in_ready), 32'd0);
    @(posedge clk); #1; rst_b = 1'b0; rdy_mode_b = 0;
    @(posedge clk); #1; rst_b = 1'b1;
    waitc(1);
    for (int i = 0; i < 9; i++) send(1, 16'(16'h0200 + i));
    waitc(3);
    chk("b_rst_sop_mask", 1, sop_mask[1], 32'h00000101);
    chk("b_rst_eop_mask", 1, eop_mask[1], 32'h00000080);
    chk("b_rst_fd_cnt", 1, 32'(fd_cnt[1]), 32'd1);
    chk("b_rst_xfers", 1, 32'(xfer_cnt[1]), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/avalon_st_source_interface.md
# avalon_st_source_interface

Avalon-ST source interface of the video IP: the transmitting end of the pixel stream. It takes processed RGB565 pixels from the IP core and presents them on an Avalon-ST source port to the next Qsys element (video output / DMA pixel sink). It frames the stream itself, generating startofpacket/endofpacket from pixel counters. A two-entry skid buffer gives full throughput under downstream backpressure with a registered ready toward the core.

## Interface
- FRAME_W, 320, pixels per line
- FRAME_H, 240, lines per frame
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-low; clears all state when 0 at a clk edge
- in_valid  input  1  core has a pixel on in_data
- in_data  input  16  RGB565 pixel from core
- in_ready  output  1  block accepts in_data this cycle; registered
- ready  input  1  Avalon-ST ready from downstream sink (readyLatency 0)
- valid  output  1  Avalon-ST valid
- data  output  16  Avalon-ST data
- startofpacket  output  1  first pixel of frame
- endofpacket  output  1  last pixel of frame
- frame_done  output  1  one-cycle pulse when the EOP beat transfers downstream

## Operation
- Input accept: in_valid && in_ready. Output transfer: valid && ready.
- Framing counters x (0..FRAME_W-1) and y (0..FRAME_H-1) advance on each input accept. x wraps to 0 and increments y; at x=FRAME_W-1, y=FRAME_H-1 both wrap to 0.
- Each accepted pixel is tagged sop = (x==0 && y==0) and eop = (x==FRAME_W-1 && y==FRAME_H-1). The 16-bit data and 2 tag bits (18 bits) travel together through the buffer.
- Storage: output register (drives valid/data/sop/eop) plus one skid register.
- States:
  - EMPTY: valid=0.
  - ONE: output register holds a beat, valid=1.
  - FULL: output register and skid register both hold beats.
- Transitions:
  - EMPTY: accept -> ONE, out<=in.
  - ONE: accept and transfer -> ONE, out<=in. Accept without transfer -> FULL, skid<=in. Transfer without accept -> EMPTY. Neither -> stay.
  - FULL: transfer -> ONE, out<=skid. Otherwise stay. No accept is possible in FULL.
- in_ready is registered as (next_state != FULL).
- While valid=1 and ready=0, data/startofpacket/endofpacket are held stable (Avalon-ST rule).
- When valid=0, startofpacket and endofpacket are 0. data holds its last value.
- frame_done=1 for exactly the cycle after an output transfer with endofpacket=1.
- Ordering is strict FIFO. No pixel is dropped or duplicated.

## Timing
- Reset (reset=0 at edge):
  - State EMPTY, x=y=0.
  - valid=0, data=16'h0000, startofpacket=0, endofpacket=0, frame_done=0, in_ready=0.
  - First cycle after release: in_ready=1.
- Reset mid-frame discards both buffered beats and restarts framing. The next accepted pixel carries sop.
- Latency: pixel accepted at edge N appears on data/valid after edge N (visible in cycle N+1). It transfers at edge N+1 if ready=1.
- Throughput: 1 pixel/cycle while ready=1 and in_valid=1. Buffer stays in ONE.
- Backpressure:
  - ready falls while in ONE and a pixel is accepted: block goes to FULL, and in_ready is 0 from the next cycle.
  - ready rises in FULL: skid moves to output and in_ready returns to 1 one cycle later.
- in_valid and ready toggling in the same cycle are handled by the transition list above; no other case exists.
- Counters are 9 bits minimum for the defaults. Widths are sized as clog2 of each parameter, with FRAME_W and FRAME_H >= 1.

## Test plan
- Reset values: hold reset=0 for 3 cycles with random in_valid/in_data and ready=1 -> valid=0, data=0, sop=eop=0, in_ready=0. After release, in_ready=1 after one edge.
- Full frame, no stall: 76800 beats with ready=1, data=beat index -> sop only on beat 0 (data 0x0000), eop only on beat 76799 (0x2BFF), one-cycle latency, a single frame_done pulse.
- Backpressure: stream 0x0001.. with ready pattern 1,0,0,1,0,1 repeating -> output sequence identical to input, data stable while ready=0, in_ready=0 only in cycles following a FULL entry. Never more than 2 beats in flight.
- Wrap-around, FRAME_W=4, FRAME_H=2: 20 beats -> eop on beats 7 and 15, sop on beats 0, 8 and 16, frame_done twice.
- Reset mid-frame, defaults: reset=0 after 1000 beats while in FULL -> both buffered beats lost. First beat after release has sop=1, and eop falls on beat 76799 after release.
- Idle gaps: in_valid=0 for 5 cycles mid-line with ready=1 -> valid=0 during the gap, sop/eop=0, and x counter unchanged across the gap.
